// File: rtl/lvds_7to1_tx_framer.sv
// lvds_7to1_tx_framer
// Transmit-side framer for a 7:1 LVDS video link (VESA 24-bit mapping).
// One pixel per tx_sclk is packed into four 7-bit data-lane words plus a
// forwarded-clock word. After reset it sends IDLE_WORDS blank words and
// then a TRAIN_WORDS-long training burst. Only then does it accept live
// pixels. The link partner can request retraining with train_req.
//
// Ports:
//   tx_sclk       in   serializer slow clock, one word per cycle
//   rst           in   asynchronous active-high reset
//   pix_data      in   {R[7:0], G[7:0], B[7:0]}
//   pix_hs/vs/de  in   sync and data-enable, qualified by pix_valid
//   pix_valid     in   upstream has a pixel
//   pix_ready     out  framer accepts a pixel (decode of state == DATA)
//   train_req     in   single-cycle retrain request
//   tx_clk_word   out  clock-lane word, bit 6 serialized first
//   tx_data_word  out  lane n in bits [7n+6:7n], bit 6 serialized first
//   link_up       out  high while in DATA
//   underflow_cnt out  saturating count of DATA cycles with no pixel
module lvds_7to1_tx_framer #(
  parameter int unsigned TRAIN_WORDS = 1024,
  parameter int unsigned IDLE_WORDS  = 16,
  parameter logic [6:0]  TRAIN_PAT   = 7'b1100011
) (
  input  logic        tx_sclk,
  input  logic        rst,
  input  logic [23:0] pix_data,
  input  logic        pix_hs,
  input  logic        pix_vs,
  input  logic        pix_de,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        train_req,
  output logic [6:0]  tx_clk_word,
  output logic [27:0] tx_data_word,
  output logic        link_up,
  output logic [15:0] underflow_cnt
);

  localparam logic [6:0]  CLK_PAT    = 7'b1100011;
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_WORDS - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_WORDS - 1);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        hs_q;
  logic        vs_q;

  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        accept;
  logic [27:0] pix_word;
  logic [27:0] blank_word;

  // Ready depends only on the registered state, never on pix_valid.
  assign pix_ready = (state == S_DATA);
  assign accept    = pix_valid & pix_ready;

  assign r = pix_data[23:16];
  assign g = pix_data[15:8];
  assign b = pix_data[7:0];

  // VESA 24-bit lane mapping: {lane3, lane2, lane1, lane0}
  assign pix_word = {1'b0, b[7:6], g[7:6], r[7:6],
                     pix_de, pix_vs, pix_hs, b[5:2],
                     b[1:0], g[5:1],
                     g[0], r[5:0]};

  // Blank word keeps the last accepted sync levels so the sink's timing is undisturbed.
  assign blank_word = {7'b0, 1'b0, vs_q, hs_q, 4'b0, 7'b0, 7'b0};

  // FSM, word counter and all registered outputs
  always_ff @(posedge tx_sclk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 16'd0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      tx_clk_word   <= 7'd0;
      tx_data_word  <= 28'd0;
      link_up       <= 1'b0;
      underflow_cnt <= 16'd0;
    end else begin
      tx_clk_word <= CLK_PAT;
      case (state)
        S_IDLE: begin
          tx_data_word <= 28'd0;
          if (cnt == IDLE_LAST) begin
            state   <= S_TRAIN;
            cnt     <= 16'd0;
            link_up <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_TRAIN: begin
          tx_data_word <= {TRAIN_PAT, TRAIN_PAT, TRAIN_PAT, TRAIN_PAT};
          // A restart request wins over finishing the burst.
          if (train_req) begin
            cnt <= 16'd0;
          end else if (cnt == TRAIN_LAST) begin
            state   <= S_DATA;
            cnt     <= 16'd0;
            link_up <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            tx_data_word <= pix_word;
            hs_q         <= pix_hs;
            vs_q         <= pix_vs;
          end else begin
            tx_data_word <= blank_word;
            if (underflow_cnt != CNT_MAX) begin
              underflow_cnt <= underflow_cnt + 16'd1;
            end
          end
          // A pixel accepted on the request cycle is still emitted above.
          if (train_req) begin
            state   <= S_TRAIN;
            cnt     <= 16'd0;
            link_up <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          cnt          <= 16'd0;
          tx_data_word <= 28'd0;
          link_up      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_7to1_tx_framer.sv
// tb_lvds_7to1_tx_framer
// Directed self-checking bench for lvds_7to1_tx_framer with the default
// parameters (IDLE_WORDS=16, TRAIN_WORDS=1024, TRAIN_PAT=7'b1100011).
module tb_lvds_7to1_tx_framer;

  logic        clk;
  logic        rst;
  logic [23:0] pix_data;
  logic        pix_hs;
  logic        pix_vs;
  logic        pix_de;
  logic        pix_valid;
  logic        pix_ready;
  logic        train_req;
  logic [6:0]  tx_clk_word;
  logic [27:0] tx_data_word;
  logic        link_up;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] TRAIN_WORD = {7'h63, 7'h63, 7'h63, 7'h63};
  // {R=A5, G=3C, B=F0}, DE=1, HS=0, VS=1
  localparam logic [27:0] WORD_A5 = {7'b0110010, 7'b1101100, 7'b0011110, 7'b0100101};
  // {R=12, G=34, B=56}, DE=1, HS=1, VS=0
  localparam logic [27:0] WORD_12 = {7'h10, 7'h55, 7'h5A, 7'h12};
  // Blank word after HS=1, VS=0
  localparam logic [27:0] BLANK_H = {7'h00, 7'b0010000, 7'h00, 7'h00};

  lvds_7to1_tx_framer #(
    .TRAIN_WORDS(1024),
    .IDLE_WORDS (16),
    .TRAIN_PAT  (7'b1100011)
  ) dut (
    .tx_sclk      (clk),
    .rst          (rst),
    .pix_data     (pix_data),
    .pix_hs       (pix_hs),
    .pix_vs       (pix_vs),
    .pix_de       (pix_de),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .train_req    (train_req),
    .tx_clk_word  (tx_clk_word),
    .tx_data_word (tx_data_word),
    .link_up      (link_up),
    .underflow_cnt(underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clk"}, 32'(tx_clk_word), 32'h0);
    chk({tag, "_data"}, 32'(tx_data_word), 32'h0);
    chk({tag, "_ready"}, 32'(pix_ready), 32'h0);
    chk({tag, "_link"}, 32'(link_up), 32'h0);
    chk({tag, "_ucnt"}, 32'(underflow_cnt), 32'h0);
  endtask

  // Startup after reset release with pix_valid held high; optional train_req in IDLE.
  task automatic startup(input int req_at);
    int bad_idle;
    int bad_train;
    bad_idle  = 0;
    bad_train = 0;
    pix_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      pix_data  = 24'($urandom);
      train_req = (i == req_at);
      step();
      train_req = 1'b0;
      if (tx_data_word !== 28'h0 || tx_clk_word !== 7'h63 ||
          pix_ready !== 1'b0 || link_up !== 1'b0) bad_idle++;
    end
    chk("idle_words_bad", 32'(bad_idle), 32'h0);
    for (int i = 1; i <= 1024; i++) begin
      pix_data = 24'($urandom);
      step();
      if (tx_data_word !== TRAIN_WORD || tx_clk_word !== 7'h63) bad_train++;
      if (i < 1024 && (pix_ready !== 1'b0 || link_up !== 1'b0)) bad_train++;
    end
    chk("train_words_bad", 32'(bad_train), 32'h0);
    chk("startup_ready", 32'(pix_ready), 32'h1);
    chk("startup_link", 32'(link_up), 32'h1);
  endtask

  // n training words with pix_ready/link_up low throughout.
  task automatic train_words(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tx_data_word !== TRAIN_WORD || pix_ready !== 1'b0 || link_up !== 1'b0) bad++;
    end
    chk(tag, 32'(bad), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    pix_data  = 24'h0;
    pix_hs    = 1'b0;
    pix_vs    = 1'b0;
    pix_de    = 1'b0;
    pix_valid = 1'b1;
    train_req = 1'b0;

    // Reset values
    #12;
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    chk("clk_word_pre_edge", 32'(tx_clk_word), 32'h0);

    // Startup: 16 zero words, 1024 training words, then ready
    startup(-1);
    chk("ucnt_after_startup", 32'(underflow_cnt), 32'h0);

    // Live pixel mapping
    pix_data = 24'hA53CF0; pix_de = 1'b1; pix_hs = 1'b0; pix_vs = 1'b1;
    step();
    chk("pix_a5_word", 32'(tx_data_word), 32'(WORD_A5));
    pix_data = 24'h123456; pix_de = 1'b1; pix_hs = 1'b1; pix_vs = 1'b0;
    step();
    chk("pix_12_word", 32'(tx_data_word), 32'(WORD_12));
    chk("pix_12_ucnt", 32'(underflow_cnt), 32'h0);

    // Underflow: blank words keep held HS/VS
    pix_valid = 1'b0;
    pix_data  = 24'hFFFFFF;
    pix_de    = 1'b1;
    pix_vs    = 1'b1;
    pix_hs    = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("blank_word", 32'(tx_data_word), 32'(BLANK_H));
      chk("blank_ucnt", 32'(underflow_cnt), 32'(i));
    end
    chk("blank_ready", 32'(pix_ready), 32'h1);

    // Drive the counter to FFFE, then 5 more empty cycles saturate it
    for (int i = 0; i < 65531; i++) step();
    chk("ucnt_fffe", 32'(underflow_cnt), 32'hFFFE);
    for (int i = 0; i < 5; i++) step();
    chk("ucnt_saturated", 32'(underflow_cnt), 32'hFFFF);
    chk("blank_after_sat", 32'(tx_data_word), 32'(BLANK_H));

    // Retrain with a pixel accepted in the same cycle
    pix_valid = 1'b1;
    pix_data  = 24'hA53CF0; pix_de = 1'b1; pix_hs = 1'b0; pix_vs = 1'b1;
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    chk("retrain_pixel_word", 32'(tx_data_word), 32'(WORD_A5));
    chk("retrain_link_low", 32'(link_up), 32'h0);
    chk("retrain_ready_low", 32'(pix_ready), 32'h0);

    // Restart at training word 500, then again on the last word of the next burst
    train_words("train_pre500", 499);
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    chk("train_w500", 32'(tx_data_word), 32'(TRAIN_WORD));
    train_words("train_pre_last", 1023);
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    chk("restart_priority_ready", 32'(pix_ready), 32'h0);
    chk("restart_priority_link", 32'(link_up), 32'h0);
    train_words("train_final_1023", 1023);
    step();
    chk("train_last_word", 32'(tx_data_word), 32'(TRAIN_WORD));
    chk("retrain_done_ready", 32'(pix_ready), 32'h1);
    chk("retrain_done_link", 32'(link_up), 32'h1);
    chk("ucnt_held", 32'(underflow_cnt), 32'hFFFF);
    pix_data = 24'h123456; pix_de = 1'b1; pix_hs = 1'b1; pix_vs = 1'b0;
    step();
    chk("post_retrain_word", 32'(tx_data_word), 32'(WORD_12));

    // Asynchronous reset in the middle of a training burst
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    train_words("train_pre_reset", 300);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    step();
    chk_all_zero("reset_held");
    rst = 1'b0;

    // Full startup repeats; train_req in IDLE has no effect
    startup(5);
    chk("ucnt_after_reset", 32'(underflow_cnt), 32'h0);
    pix_data = 24'hA53CF0; pix_de = 1'b1; pix_hs = 1'b0; pix_vs = 1'b1;
    step();
    chk("final_pixel_word", 32'(tx_data_word), 32'(WORD_A5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
